// File: rtl/neuron_alu_driver.sv
// rtl/neuron_alu_driver.sv - sequences a combinational ALU slice through multiply/accumulate/threshold per neuron
// Optional thresholded-ReLU output: define NEURON_RELU_EN.
module neuron_alu_driver #(
    parameter int nBits = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [nBits-1:0] threshold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [nBits-1:0] in_a,
    input  logic [nBits-1:0] in_w,
    output logic [2:0]       alu_ctrl,
    output logic [nBits-1:0] alu_a,
    output logic [nBits-1:0] alu_c,
    input  logic [nBits-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [nBits-1:0] out_value,
    output logic             out_fire
);

    typedef enum logic [2:0] {IDLE, MUL, ACC, ACT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [nBits-1:0] acc;
    logic [nBits-1:0] prod;
    logic [nBits-1:0] thr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            prod      <= '0;
            thr       <= '0;
            out_value <= '0;
            out_fire  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= len;
                        thr   <= threshold;
                        acc   <= '0;
                        state <= (len != '0) ? MUL : ACT;
                    end
                end
                MUL: begin
                    if (in_valid) begin
                        prod  <= alu_result;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc   <= alu_result;
                    cnt   <= cnt - 1'b1;
                    state <= (cnt == CNT_W'(1)) ? ACT : MUL;
                end
                ACT: begin
                    out_fire <= alu_result[0];
`ifdef NEURON_RELU_EN
                    out_value <= alu_result[0] ? acc : '0;
`else
                    out_value <= acc;
`endif
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Slice controls decode straight from the state register; MUL passes operands through.
    always_comb begin
        alu_ctrl = 3'b111;
        alu_a    = '0;
        alu_c    = '0;
        case (state)
            MUL: begin
                alu_ctrl = 3'b001;
                alu_a    = in_a;
                alu_c    = in_w;
            end
            ACC: begin
                alu_ctrl = 3'b000;
                alu_a    = prod;
                alu_c    = acc;
            end
            ACT: begin
                alu_ctrl = 3'b010;
                alu_a    = acc;
                alu_c    = thr;
            end
            default: begin
                alu_ctrl = 3'b111;
                alu_a    = '0;
                alu_c    = '0;
            end
        endcase
    end

    assign in_ready = (state == MUL);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_neuron_alu_driver.sv
// tb/tb_neuron_alu_driver.sv - directed bench for neuron_alu_driver with a behavioural ALU slice
module tb_neuron_alu_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic [31:0] threshold;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_w;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_c;
    logic [31:0] alu_result;
    logic        busy;
    logic        done;
    logic [31:0] out_value;
    logic        out_fire;

    int passed = 0;
    int total  = 0;

    logic [31:0] pa [4];
    logic [31:0] pw [4];

    int          dcyc;
    logic [31:0] rmask;
    logic [20:0] trace;
    int          done_seen;

    always #5 clk = ~clk;

    neuron_alu_driver #(.nBits(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .threshold(threshold),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_c(alu_c), .alu_result(alu_result),
        .busy(busy), .done(done), .out_value(out_value), .out_fire(out_fire)
    );

    // Behavioural ALU_Child: add, multiply, signed set-if-non-negative of (a - c).
    always_comb begin
        alu_result = 32'h0;
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_c;
            3'b001:  alu_result = alu_a * alu_c;
            3'b010:  alu_result = {31'b0, ($signed(alu_a) >= $signed(alu_c))};
            default: alu_result = 32'h0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // Entered and left at #1 after a rising edge with the DUT in IDLE; cycle 0 carries start.
    task automatic run(input int n, input logic [31:0] t, input int stall_idx, input int stall_n,
                       input int pulse_at, output int done_cyc, output logic [31:0] rm,
                       output logic [20:0] tr);
        int  k;
        int  stall;
        logic take;
        k = 0; stall = 0; done_cyc = -1; rm = '0; tr = '0;
        for (int c = 0; c < 32; c++) begin
            rm[c] = in_ready;
            tr = {tr[17:0], alu_ctrl};
            if (done) begin
                done_cyc = c;
                break;
            end
            start     = (c == 0) || (c == pulse_at);
            len       = 8'(n);
            threshold = t;
            in_valid  = (k < n);
            if (k < n) begin
                in_a = pa[k];
                in_w = pw[k];
            end
            if (in_ready && k == stall_idx && stall < stall_n) begin
                in_valid = 1'b0;
                stall++;
            end
            take = in_ready && in_valid;
            @(posedge clk);
            if (take) k++;
            #1;
        end
        start = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; threshold = '0;
        in_valid = 1'b0; in_a = '0; in_w = '0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_alu_ctrl", {29'b0, alu_ctrl}, 32'd7);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_c", alu_c, 32'd0);
        check("rst_out_value", out_value, 32'd0);
        check("rst_out_fire", {31'b0, out_fire}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // len=3, (2,3),(4,-1),(5,1): 6-4+5 = 7
        pa[0] = 32'd2; pw[0] = 32'd3;
        pa[1] = 32'd4; pw[1] = 32'hFFFF_FFFF;
        pa[2] = 32'd5; pw[2] = 32'd1;
        run(3, 32'd0, -1, 0, -1, dcyc, rmask, trace);
        check("t1_done_cycle", 32'(dcyc), 32'd8);
        check("t1_out_value", out_value, 32'd7);
        check("t1_out_fire", {31'b0, out_fire}, 32'd1);
        check("t1_in_ready_cycles", rmask, 32'h0000_002A);

        // len=1, (-3,4): -12 fails the threshold
        pa[0] = 32'hFFFF_FFFD; pw[0] = 32'd4;
        run(1, 32'd0, -1, 0, -1, dcyc, rmask, trace);
        check("t2_done_cycle", 32'(dcyc), 32'd4);
        check("t2_out_fire", {31'b0, out_fire}, 32'd0);
`ifdef NEURON_RELU_EN
        check("t2_out_value", out_value, 32'd0);
`else
        check("t2_out_value", out_value, 32'hFFFF_FFF4);
`endif

        // len=0 against thresholds 0 and 1
        run(0, 32'd0, -1, 0, -1, dcyc, rmask, trace);
        check("t3_done_cycle", 32'(dcyc), 32'd2);
        check("t3_out_fire", {31'b0, out_fire}, 32'd1);
        check("t3_out_value", out_value, 32'd0);
        run(0, 32'd1, -1, 0, -1, dcyc, rmask, trace);
        check("t3b_out_fire", {31'b0, out_fire}, 32'd0);
        check("t3b_out_value", out_value, 32'd0);

        // wrapping product plus a 3-cycle stall before pair 1
        pa[0] = 32'h0001_0000; pw[0] = 32'h0001_0000;
        pa[1] = 32'd7;         pw[1] = 32'd7;
        run(2, 32'd0, 1, 3, -1, dcyc, rmask, trace);
        check("t4_done_cycle", 32'(dcyc), 32'd9);
        check("t4_out_value", out_value, 32'd49);
        check("t4_out_fire", {31'b0, out_fire}, 32'd1);

        // spurious start at cycle 3 is ignored; ctrl sequence traced
        pa[0] = 32'd3; pw[0] = 32'd5;
        pa[1] = 32'd2; pw[1] = 32'd2;
        run(2, 32'd20, -1, 0, 3, dcyc, rmask, trace);
        check("t5_done_cycle", 32'(dcyc), 32'd6);
        check("t5_out_value", out_value, 32'd19);
        check("t5_out_fire", {31'b0, out_fire}, 32'd0);
        check("t5_ctrl_trace", {11'b0, trace},
              {11'b0, 3'b111, 3'b001, 3'b000, 3'b001, 3'b000, 3'b010, 3'b111});

        // reset in the middle of a len=2 run
        start = 1'b1; len = 8'd2; threshold = 32'd0; in_valid = 1'b1;
        in_a = 32'd6; in_w = 32'd6;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("t6_busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_alu_ctrl", {29'b0, alu_ctrl}, 32'd7);
        check("t6_in_ready", {31'b0, in_ready}, 32'd0);
        check("t6_alu_a", alu_a, 32'd0);
        check("t6_out_value", out_value, 32'd0);
        check("t6_out_fire", {31'b0, out_fire}, 32'd0);
        done_seen = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        in_valid = 1'b0;
        check("t6_no_done_after_reset", 32'(done_seen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
